rx_frame_ctrl: RTL

Frame-level controller behind the UART receiver control block. It sequences per-bit samples into bytes, qualifies each frame with the receiver's done/error indications and a stop-phase timeout, and buffers good bytes in a small FIFO with a valid/ready output. It sits between the receiver control block and the register/host interface, and reports sticky framing and overrun status.

---
 rtl/rx_pkg.sv | 15 +
 rtl/rx_frame_ctrl_if.sv | 12 +
 rtl/rx_fifo.sv | 71 +++++++
 rtl/rx_frame_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the UART frame-level receive controller.
package rx_pkg;

  // Frame sequencer states; the encoding is fixed so status readback stays stable.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DATA  = 2'b01,
    STOP  = 2'b10,
    DRAIN = 2'b11
  } rx_state_t;

  localparam int RX_DATA_BITS   = 8;
  localparam int RX_TIMEOUT_DEF = 48;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Byte stream from the frame controller to the register/host side (valid/ready).
interface rx_frame_ctrl_if;
  import rx_pkg::*;

  logic [RX_DATA_BITS-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/rx_fifo.sv
// Small synchronous byte FIFO with a registered head-of-queue output.
// The head byte is precomputed each cycle so the consumer sees it without a read latency.
module rx_fifo
  import rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [RX_DATA_BITS-1:0] din,
  input  logic                    pop,
  output logic [RX_DATA_BITS-1:0] dout,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [RX_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           rd_nxt;
  logic [AW:0]             count;
  logic [AW:0]             count_nxt;
  logic                    do_push;
  logic                    do_pop;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    do_pop    = pop & (count != '0);
    do_push   = push & ((count != FULL_CNT) | do_pop);
    rd_nxt    = do_pop ? rd_ptr + PTR_ONE : rd_ptr;
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CNT_ONE;
    else if (!do_push && do_pop)
      count_nxt = count - CNT_ONE;
  end

  // Storage array; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers, occupancy flags and the registered head byte (bypassing a write to the new head slot).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == FULL_CNT);
      empty  <= (count_nxt == '0);
      if (count_nxt != '0)
        dout <= (do_push && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame-level receive controller: assembles sampled bits into bytes, qualifies each
// frame with the receiver's stop-bit result and a stop-phase timeout, and queues good
// bytes in a FIFO. Optional macro RX_STATUS_CNT_EN adds saturating event counters.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = RX_TIMEOUT_DEF
) (
  input  logic                   Bclkx16_,
  input  logic                   rst,
  input  logic                   rx_en,
  input  logic                   rx_bit,
  input  logic                   rx_bit_stb,
  input  logic                   rx_done,
  input  logic                   rx_err,
  rx_frame_ctrl_if.master        m,
  output logic                   ferr,
  output logic                   ovr,
  input  logic                   clr_status,
  output logic                   busy
`ifdef RX_STATUS_CNT_EN
  , output logic [7:0]           ferr_cnt
  , output logic [7:0]           ovr_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [2:0]    LAST_BIT = 3'(RX_DATA_BITS - 1);

  rx_state_t               state;
  logic [2:0]              bit_cnt;
  logic [RX_DATA_BITS-1:0] shreg;
  logic [TW-1:0]           tmo_cnt;
  logic                    push_req;
  logic                    tmo_hit;
  logic                    ferr_evt;
  logic                    ovr_evt;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign pop       = m.m_valid & m.m_ready;
  assign ovr_evt   = push_req & fifo_full & ~pop;
  assign m.m_valid = ~fifo_empty;

  // Framing error sources: bad start bit, early stop indication, bad stop bit, or stop timeout.
  always_comb begin
    ferr_evt = 1'b0;
    case (state)
      IDLE:    ferr_evt = rx_en & rx_bit_stb & rx_bit;
      DATA:    ferr_evt = rx_done | rx_err;
      STOP:    ferr_evt = rx_err | (~rx_done & tmo_hit);
      default: ferr_evt = 1'b0;
    endcase
  end

  // Frame sequencer; a bad start bit parks in DRAIN until the receiver finishes the frame.
  always_ff @(posedge Bclkx16_) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tmo_cnt  <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_en && rx_bit_stb) begin
            busy <= 1'b1;
            if (!rx_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state   <= DRAIN;
              tmo_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (rx_done || rx_err) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_bit_stb) begin
            shreg   <= {rx_bit, shreg[RX_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state   <= STOP;
              tmo_cnt <= '0;
            end
          end
        end
        STOP: begin
          if (rx_err) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_done) begin
            push_req <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else if (tmo_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: begin
          if (rx_done || rx_err || tmo_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
      endcase
    end
  end

  // Sticky status flags; a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Bclkx16_) begin
    if (rst) begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ferr <= ferr_evt | (ferr & ~clr_status);
      ovr  <= ovr_evt  | (ovr  & ~clr_status);
    end
  end

`ifdef RX_STATUS_CNT_EN
  // Saturating event counters; a clear coinciding with an event leaves a count of one.
  always_ff @(posedge Bclkx16_) begin
    if (rst) begin
      ferr_cnt <= '0;
      ovr_cnt  <= '0;
    end else begin
      if (clr_status)
        ferr_cnt <= {7'b0, ferr_evt};
      else if (ferr_evt && ferr_cnt != 8'hFF)
        ferr_cnt <= ferr_cnt + 8'd1;
      if (clr_status)
        ovr_cnt <= {7'b0, ovr_evt};
      else if (ovr_evt && ovr_cnt != 8'hFF)
        ovr_cnt <= ovr_cnt + 8'd1;
    end
  end
`endif

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Bclkx16_),
    .rst   (rst),
    .push  (push_req),
    .din   (shreg),
    .pop   (pop),
    .dout  (m.m_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
